// File: rtl/instr_fetch_pkg.sv
// Shared constants, state encoding and the fetch-fault helper for the fetch stage.
package instr_fetch_pkg;

   localparam int          ADDR_W    = 32;
   localparam int          INSTR_W   = 32;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] ROM_LIMIT = 32'h0000_001C;
   localparam logic [31:0] NOP       = 32'h0000_0013;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   // An address faults when it lies beyond the populated ROM or is not word aligned.
   function automatic logic fetch_fault(input logic [ADDR_W-1:0] addr);
      return (addr >= ROM_LIMIT[ADDR_W-1:0]) || (addr[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter: async reset, redirect load (priority) and +4 increment.
module pc_reg #(
   parameter int             W       = 32,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_pc,
   input  logic         inc,
   output logic [W-1:0] pc,
   output logic [W-1:0] pc_plus4
);

   logic [W-1:0] pc_reg_q;

   // Adder wraps naturally modulo 2^W.
   assign pc_plus4 = pc_reg_q + W'(4);
   assign pc       = pc_reg_q;

   // PC update: a redirect load wins over the sequential increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_reg_q <= RST_VAL;
      end else if (load) begin
         pc_reg_q <= load_pc;
      end else if (inc) begin
         pc_reg_q <= pc_plus4;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, ROM address, IF/ID slot with valid/ready, fault halt.
module instr_fetch
   import instr_fetch_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   output logic [ADDR_W-1:0]  rom_address,
   input  logic [INSTR_W-1:0] rom_data,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   input  logic               id_ready,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [ADDR_W-1:0]  if_pc,
   output logic [ADDR_W-1:0]  if_pc_plus4,
   output logic               halted,
   output logic [ADDR_W-1:0]  fault_pc,
   output logic [31:0]        fetch_count
);

   state_t             state_reg;
   state_t             state_next;

   logic [ADDR_W-1:0]  pc;
   logic [ADDR_W-1:0]  pc_plus4;

   logic               if_valid_reg;
   logic [INSTR_W-1:0] if_instr_reg;
   logic [ADDR_W-1:0]  if_pc_reg;
   logic [ADDR_W-1:0]  if_pc_plus4_reg;
   logic [ADDR_W-1:0]  fault_pc_reg;
   logic [31:0]        fetch_count_reg;

   logic               xfer;
   logic               slot_free;
   logic               fault_now;
   logic               redirect_ok;
   logic               pc_inc;
   logic               fault_take;
   logic               halt_drain;

   assign xfer        = if_valid_reg && id_ready;
   assign slot_free   = !if_valid_reg || id_ready;
   assign fault_now   = fetch_fault(pc);
   assign redirect_ok = !fetch_fault(redirect_pc);

   pc_reg #(
      .W       (ADDR_W),
      .RST_VAL (RESET_PC[ADDR_W-1:0])
   ) u_pc_reg (
      .clk      (clk),
      .reset    (reset),
      .load     (redirect_valid),
      .load_pc  (redirect_pc),
      .inc      (pc_inc),
      .pc       (pc),
      .pc_plus4 (pc_plus4)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= RUN;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next state: redirect decides RUN/HALT by target validity, otherwise a fault halts.
   always_comb begin
      state_next = state_reg;
      if (redirect_valid) begin
         state_next = redirect_ok ? RUN : HALT;
      end else if ((state_reg == RUN) && slot_free && fault_now) begin
         state_next = HALT;
      end
   end

   // Control decode from state and handshake; redirect masks every other action.
   always_comb begin
      pc_inc     = 1'b0;
      fault_take = 1'b0;
      halt_drain = 1'b0;
      halted     = (state_reg == HALT);
      if (!redirect_valid) begin
         if (state_reg == RUN) begin
            pc_inc     = slot_free && !fault_now;
            fault_take = slot_free && fault_now;
         end else begin
            halt_drain = xfer;
         end
      end
   end

   // IF/ID slot: flush on redirect, capture on fetch, empty on fault or drained while halted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         if_valid_reg    <= 1'b0;
         if_instr_reg    <= '0;
         if_pc_reg       <= '0;
         if_pc_plus4_reg <= '0;
      end else if (redirect_valid) begin
         if_valid_reg    <= 1'b0;
      end else if (pc_inc) begin
         if_valid_reg    <= 1'b1;
         if_instr_reg    <= rom_data;
         if_pc_reg       <= pc;
         if_pc_plus4_reg <= pc_plus4;
      end else if (fault_take || halt_drain) begin
         if_valid_reg    <= 1'b0;
      end
   end

   // Record the offending address for a bad redirect target or a faulting fetch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fault_pc_reg <= '0;
      end else if (redirect_valid) begin
         if (!redirect_ok) begin
            fault_pc_reg <= redirect_pc;
         end
      end else if (fault_take) begin
         fault_pc_reg <= pc;
      end
   end

   // Completed transfers, counted even when a redirect flushes the slot in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_count_reg <= '0;
      end else if (xfer) begin
         fetch_count_reg <= fetch_count_reg + 32'd1;
      end
   end

   assign rom_address = pc;
   assign if_valid    = if_valid_reg;
   assign if_instr    = if_instr_reg;
   assign if_pc       = if_pc_reg;
   assign if_pc_plus4 = if_pc_plus4_reg;
   assign fault_pc    = fault_pc_reg;
   assign fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed table-driven bench for instr_fetch with a small combinational ROM model.
module tb_instr_fetch;

   logic        clk;
   logic        reset;
   logic [31:0] rom_address;
   logic [31:0] rom_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_ready;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic        halted;
   logic [31:0] fault_pc;
   logic [31:0] fetch_count;

   int errors = 0;
   int checks = 0;

   logic [31:0] rom_mem [0:6];

   typedef struct {
      logic        rv;
      logic [31:0] rpc;
      logic        rdy;
      logic        ev;
      logic [31:0] epc;
      logic [31:0] einstr;
      logic        eh;
      logic [31:0] efpc;
      logic [31:0] erom;
      logic [31:0] ecnt;
   } vec_t;

   vec_t vecs[$];

   instr_fetch dut (
      .clk            (clk),
      .reset          (reset),
      .rom_address    (rom_address),
      .rom_data       (rom_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_ready       (id_ready),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_pc_plus4    (if_pc_plus4),
      .halted         (halted),
      .fault_pc       (fault_pc),
      .fetch_count    (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Unmapped or misaligned addresses return garbage that must never be captured.
   always_comb begin
      if ((rom_address < 32'h1C) && (rom_address[1:0] == 2'b00))
         rom_data = rom_mem[rom_address[4:2]];
      else
         rom_data = 32'hDEAD_BEEF;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic add(input logic rv, input logic [31:0] rpc, input logic rdy,
                      input logic ev, input logic [31:0] epc, input logic [31:0] einstr,
                      input logic eh, input logic [31:0] efpc, input logic [31:0] erom,
                      input logic [31:0] ecnt);
      vec_t v;
      v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.ev = ev; v.epc = epc; v.einstr = einstr;
      v.eh = eh; v.efpc = efpc; v.erom = erom; v.ecnt = ecnt;
      vecs.push_back(v);
   endtask

   initial begin
      rom_mem[0] = 32'h0040_0093;
      rom_mem[1] = 32'h0080_0113;
      rom_mem[2] = 32'h0020_81B3;
      rom_mem[3] = 32'h4011_0233;
      rom_mem[4] = 32'h0042_02B3;
      rom_mem[5] = 32'h0000_0013;
      rom_mem[6] = 32'h4021_0463;

      //   rv  rpc    rdy ev  epc    instr          eh  fault  rom    count
      add(0, 32'h00, 1, 1, 32'h00, 32'h0040_0093, 0, 32'h00, 32'h04, 0);
      add(0, 32'h00, 1, 1, 32'h04, 32'h0080_0113, 0, 32'h00, 32'h08, 1);
      add(0, 32'h00, 1, 1, 32'h08, 32'h0020_81B3, 0, 32'h00, 32'h0C, 2);
      add(0, 32'h00, 0, 1, 32'h08, 32'h0020_81B3, 0, 32'h00, 32'h0C, 2);
      add(0, 32'h00, 0, 1, 32'h08, 32'h0020_81B3, 0, 32'h00, 32'h0C, 2);
      add(0, 32'h00, 0, 1, 32'h08, 32'h0020_81B3, 0, 32'h00, 32'h0C, 2);
      add(0, 32'h00, 1, 1, 32'h0C, 32'h4011_0233, 0, 32'h00, 32'h10, 3);
      add(0, 32'h00, 1, 1, 32'h10, 32'h0042_02B3, 0, 32'h00, 32'h14, 4);
      add(1, 32'h04, 1, 0, 32'h00, 32'h0000_0000, 0, 32'h00, 32'h04, 5);
      add(0, 32'h00, 1, 1, 32'h04, 32'h0080_0113, 0, 32'h00, 32'h08, 5);
      add(0, 32'h00, 1, 1, 32'h08, 32'h0020_81B3, 0, 32'h00, 32'h0C, 6);
      add(0, 32'h00, 1, 1, 32'h0C, 32'h4011_0233, 0, 32'h00, 32'h10, 7);
      add(0, 32'h00, 1, 1, 32'h10, 32'h0042_02B3, 0, 32'h00, 32'h14, 8);
      add(0, 32'h00, 1, 1, 32'h14, 32'h0000_0013, 0, 32'h00, 32'h18, 9);
      add(0, 32'h00, 1, 1, 32'h18, 32'h4021_0463, 0, 32'h00, 32'h1C, 10);
      add(0, 32'h00, 1, 0, 32'h00, 32'h0000_0000, 1, 32'h1C, 32'h1C, 11);
      add(0, 32'h00, 1, 0, 32'h00, 32'h0000_0000, 1, 32'h1C, 32'h1C, 11);
      add(1, 32'h06, 1, 0, 32'h00, 32'h0000_0000, 1, 32'h06, 32'h06, 11);
      add(0, 32'h00, 1, 0, 32'h00, 32'h0000_0000, 1, 32'h06, 32'h06, 11);
      add(1, 32'h00, 1, 0, 32'h00, 32'h0000_0000, 0, 32'h06, 32'h00, 11);
      add(0, 32'h00, 1, 1, 32'h00, 32'h0040_0093, 0, 32'h06, 32'h04, 11);
      add(1, 32'h1C, 1, 0, 32'h00, 32'h0000_0000, 1, 32'h1C, 32'h1C, 12);
      add(1, 32'h18, 1, 0, 32'h00, 32'h0000_0000, 0, 32'h1C, 32'h18, 12);
      add(0, 32'h00, 1, 1, 32'h18, 32'h4021_0463, 0, 32'h1C, 32'h1C, 12);
      add(0, 32'h00, 0, 1, 32'h18, 32'h4021_0463, 0, 32'h1C, 32'h1C, 12);
      add(0, 32'h00, 1, 0, 32'h00, 32'h0000_0000, 1, 32'h1C, 32'h1C, 13);

      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      id_ready       = 1'b1;
      step();
      step();

      check("reset if_valid",    {31'b0, if_valid}, 32'h0);
      check("reset if_instr",    if_instr,          32'h0);
      check("reset if_pc",       if_pc,             32'h0);
      check("reset if_pc_plus4", if_pc_plus4,       32'h0);
      check("reset halted",      {31'b0, halted},   32'h0);
      check("reset fault_pc",    fault_pc,          32'h0);
      check("reset count",       fetch_count,       32'h0);
      check("reset rom_address", rom_address,       32'h0);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         redirect_valid = vecs[i].rv;
         redirect_pc    = vecs[i].rpc;
         id_ready       = vecs[i].rdy;
         step();
         $display("vec %0d: rv=%0b rpc=%08h rdy=%0b -> valid=%0b pc=%08h instr=%08h halted=%0b fpc=%08h rom=%08h cnt=%0d",
                  i, vecs[i].rv, vecs[i].rpc, vecs[i].rdy, if_valid, if_pc, if_instr,
                  halted, fault_pc, rom_address, fetch_count);
         check($sformatf("vec%0d if_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].ev});
         check($sformatf("vec%0d halted", i),   {31'b0, halted},   {31'b0, vecs[i].eh});
         check($sformatf("vec%0d fault_pc", i), fault_pc,          vecs[i].efpc);
         check($sformatf("vec%0d rom_addr", i), rom_address,       vecs[i].erom);
         check($sformatf("vec%0d count", i),    fetch_count,       vecs[i].ecnt);
         if (vecs[i].ev) begin
            check($sformatf("vec%0d if_pc", i),       if_pc,       vecs[i].epc);
            check($sformatf("vec%0d if_instr", i),    if_instr,    vecs[i].einstr);
            check($sformatf("vec%0d if_pc_plus4", i), if_pc_plus4, vecs[i].epc + 32'd4);
         end
      end
      redirect_valid = 1'b0;

      // Recover from halt, fill the slot, then stall with a valid instruction held.
      redirect_valid = 1'b1;
      redirect_pc    = 32'h08;
      id_ready       = 1'b1;
      step();
      $display("seq redirect 08: valid=%0b halted=%0b rom=%08h", if_valid, halted, rom_address);
      check("seq redir valid",  {31'b0, if_valid}, 32'h0);
      check("seq redir halted", {31'b0, halted},   32'h0);
      redirect_valid = 1'b0;
      step();
      id_ready = 1'b0;
      step();
      $display("seq stall: valid=%0b pc=%08h cnt=%0d", if_valid, if_pc, fetch_count);
      check("seq stall valid", {31'b0, if_valid}, 32'h1);
      check("seq stall if_pc", if_pc,             32'h08);
      check("seq stall count", fetch_count,       32'd13);

      // Reset between clock edges must clear everything without waiting for an edge.
      #2 reset = 1'b1;
      #1;
      $display("seq async reset: valid=%0b instr=%08h pc=%08h rom=%08h cnt=%0d",
               if_valid, if_instr, if_pc, rom_address, fetch_count);
      check("async if_valid",    {31'b0, if_valid}, 32'h0);
      check("async if_instr",    if_instr,          32'h0);
      check("async if_pc",       if_pc,             32'h0);
      check("async if_pc_plus4", if_pc_plus4,       32'h0);
      check("async halted",      {31'b0, halted},   32'h0);
      check("async fault_pc",    fault_pc,          32'h0);
      check("async count",       fetch_count,       32'h0);
      check("async rom_address", rom_address,       32'h0);
      @(negedge clk);
      reset    = 1'b0;
      id_ready = 1'b1;
      step();
      $display("seq after reset: valid=%0b pc=%08h instr=%08h", if_valid, if_pc, if_instr);
      check("post reset valid", {31'b0, if_valid}, 32'h1);
      check("post reset if_pc", if_pc,             32'h00);
      check("post reset instr", if_instr,          32'h0040_0093);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage and initiator on the instruction-ROM interface. It holds the PC, drives a word address to the combinational program ROM, and captures the returned instruction into an IF/ID output register. It uses a valid/ready handshake toward decode, accepts branch/jump redirects from execute, and halts on fetch faults (out-of-range or misaligned PC).

Parameters:
ADDR_W, 32, PC and ROM address width
INSTR_W, 32, instruction width
RESET_PC, 32'h0000_0000, PC value loaded on reset
ROM_LIMIT, 32'h0000_001C, first byte address beyond the populated ROM; fetch at pc >= ROM_LIMIT is a fault

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
rom_address  out  ADDR_W  address to ROM; equals pc combinationally
rom_data  in  INSTR_W  ROM instruction for rom_address, same cycle
redirect_valid  in  1  branch/jump taken; single-cycle pulse
redirect_pc  in  ADDR_W  redirect target
id_ready  in  1  decode can accept the IF/ID slot this cycle
if_valid  out  1  IF/ID slot holds a valid instruction
if_instr  out  INSTR_W  fetched instruction
if_pc  out  ADDR_W  address of if_instr
if_pc_plus4  out  ADDR_W  if_pc + 4, modulo 2^ADDR_W
halted  out  1  fetch stopped on a fault
fault_pc  out  ADDR_W  PC that caused the fault
fetch_count  out  32  number of completed transfers (if_valid && id_ready)

Behaviour:
- Reset (async, any time, including mid-fetch): pc=RESET_PC, state=RUN, if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=0, halted=0, fault_pc=0, fetch_count=0.
- States: RUN and HALT.
- xfer = if_valid && id_ready. slot_free = !if_valid || id_ready.
- fault_now = (pc >= ROM_LIMIT) || (pc[1:0] != 0).
- Priority at each rising edge:
  1. redirect_valid:
     - if_valid <= 0 (flush).
     - If redirect_pc[1:0]==0 and redirect_pc < ROM_LIMIT: pc <= redirect_pc, state <= RUN, halted <= 0.
     - Otherwise: pc <= redirect_pc, state <= HALT, halted <= 1, fault_pc <= redirect_pc.
  2. RUN && slot_free && !fault_now:
     - if_instr <= rom_data, if_pc <= pc, if_pc_plus4 <= pc+4, if_valid <= 1, pc <= pc+4.
  3. RUN && slot_free && fault_now:
     - if_valid <= 0, state <= HALT, halted <= 1, fault_pc <= pc. pc holds.
  4. RUN && !slot_free (stall): pc and the slot hold unchanged.
  5. HALT && xfer: if_valid <= 0. No new fetch while halted.
- fetch_count increments on every xfer, including the cycle a redirect flushes the slot (the consumer took it). It wraps modulo 2^32.
- Latency: a redirect at edge N gives if_valid=1 with if_pc=target after edge N+1. Steady state is one instruction per cycle when id_ready=1.
- rom_data is undefined for unmapped addresses. The ROM_LIMIT check guarantees it is never captured.
- The pc+4 adder wraps modulo 2^ADDR_W. In practice the limit check stops it earlier.

Decomposition:
- Shared package: ADDR_W, INSTR_W, RESET_PC, ROM_LIMIT, state encoding (RUN=1'b0, HALT=1'b1), NOP constant 32'h0000_0013.
- One sub-module, pc_reg: PC register with async reset, load (redirect), increment enable, and +4 adder outputs.
- The handshake slot and fault FSM live in instr_fetch.

Test Plan:
- Reset, ROM with 00400093@0x00 and 00800113@0x04, id_ready=1 -> cycle 1: if_valid=1, if_pc=0x00, if_instr=00400093. Cycle 2: if_pc=0x04, if_instr=00800113, if_pc_plus4=0x08.
- id_ready=0 for 3 cycles while if_pc=0x08 -> if_instr stays 002081B3, rom_address stays 0x0C, fetch_count unchanged. On release, next if_pc=0x0C.
- redirect_valid with redirect_pc=0x04 while if_pc=0x10 -> next cycle if_valid=0. The following cycle if_pc=0x04, if_instr=00800113.
- Run sequentially to pc=0x1C -> after if_pc=0x18 (40210463), halted=1, fault_pc=0x1C, if_valid=0, rom_address held at 0x1C.
- redirect_pc=0x06 -> halted=1, fault_pc=0x06. Then redirect_pc=0x00 -> halted=0, if_pc=0x00 two edges later.
- Assert reset mid-stall with if_valid=1 -> all outputs zero immediately (asynchronous, no clock edge needed), rom_address=RESET_PC, fetch_count=0.
